// File: rtl/aoi_pla_pipe.sv
// Programmable AND-OR(-invert) array behind a 2-stage valid/ready pipeline.
// The AND/OR planes are rewritten through a config port that only commits while the pipe is empty.
module aoi_pla_pipe #(
  parameter  int unsigned N_IN   = 5,
  parameter  int unsigned N_TERM = 4,
  parameter  int unsigned N_OUT  = 2,
  localparam int unsigned MAX_TO = (N_TERM > N_OUT) ? N_TERM : N_OUT,
  localparam int unsigned AW     = (MAX_TO > 1) ? $clog2(MAX_TO) : 1,
  localparam int unsigned CW     = (N_IN > N_TERM + 1) ? N_IN : N_TERM + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic              cfg_sel_i,
  input  logic [AW-1:0]     cfg_addr_i,
  input  logic [CW-1:0]     cfg_wdata_i,
  output logic              cfg_ready_o,
  output logic              cfg_err_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N_IN-1:0]   in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_OUT-1:0]  out_data_o
);

  logic [N_IN-1:0]   and_mask_q [N_TERM];
  logic [N_IN-1:0]   and_mask_d [N_TERM];
  logic [N_TERM-1:0] or_mask_q  [N_OUT];
  logic [N_TERM-1:0] or_mask_d  [N_OUT];
  logic [N_OUT-1:0]  inv_q, inv_d;

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [N_TERM-1:0] term_q, term_d;
  logic [N_OUT-1:0]  out_q, out_d;
  logic              cfg_err_q, cfg_err_d;

  logic              s1_adv_c, s2_adv_c, pipe_empty_c, accept_c;
  logic              addr_ok_c, cfg_commit_c;
  logic [N_TERM-1:0] term_c;
  logic [N_OUT-1:0]  y_c;

  // Handshakes; a config write on an empty pipe takes priority over a new beat.
  always_comb begin
    addr_ok_c    = 1'b0;
    s2_adv_c     = ~s2_valid_q | out_ready_i;
    s1_adv_c     = ~s1_valid_q | s2_adv_c;
    pipe_empty_c = ~s1_valid_q & ~s2_valid_q;
    in_ready_o   = s1_adv_c & ~(cfg_we_i & pipe_empty_c);
    cfg_ready_o  = pipe_empty_c & (cfg_we_i | ~in_valid_i);
    accept_c     = in_valid_i & in_ready_o;
    if (cfg_sel_i) begin
      addr_ok_c = (32'(cfg_addr_i) < N_OUT);
    end else begin
      addr_ok_c = (32'(cfg_addr_i) < N_TERM);
    end
    cfg_commit_c = cfg_we_i & cfg_ready_o & addr_ok_c;
  end

  // AND plane: an all-zero mask is an unused term and evaluates to 0.
  always_comb begin
    term_c = '0;
    for (int unsigned t = 0; t < N_TERM; t++) begin
      term_c[t] = (|and_mask_q[t]) & (&(in_data_i | ~and_mask_q[t]));
    end
  end

  // OR plane plus per-output inversion, fed from the stage-1 term register.
  always_comb begin
    y_c = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      y_c[o] = (|(term_q & or_mask_q[o])) ^ inv_q[o];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    term_d     = term_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    if (s1_adv_c) begin
      s1_valid_d = accept_c;
      if (accept_c) begin
        term_d = term_c;
      end
    end
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = y_c;
      end
    end
  end

  always_comb begin
    and_mask_d = and_mask_q;
    or_mask_d  = or_mask_q;
    inv_d      = inv_q;
    cfg_err_d  = cfg_we_i & ~cfg_commit_c;
    for (int unsigned t = 0; t < N_TERM; t++) begin
      if (cfg_commit_c && !cfg_sel_i && (cfg_addr_i == AW'(t))) begin
        and_mask_d[t] = cfg_wdata_i[N_IN-1:0];
      end
    end
    for (int unsigned o = 0; o < N_OUT; o++) begin
      if (cfg_commit_c && cfg_sel_i && (cfg_addr_i == AW'(o))) begin
        or_mask_d[o] = cfg_wdata_i[N_TERM-1:0];
        inv_d[o]     = cfg_wdata_i[N_TERM];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < N_TERM; t++) begin
        and_mask_q[t] <= '0;
      end
      for (int unsigned o = 0; o < N_OUT; o++) begin
        or_mask_q[o] <= '0;
      end
      inv_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      term_q     <= '0;
      out_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      and_mask_q <= and_mask_d;
      or_mask_q  <= or_mask_d;
      inv_q      <= inv_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      term_q     <= term_d;
      out_q      <= out_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_data_o  = out_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_aoi_pla_pipe.sv
// Scoreboard bench for aoi_pla_pipe: directed scenarios followed by randomized traffic,
// with expected results computed from a sum-of-products model of the configured planes.
module tb_aoi_pla_pipe;
  localparam int unsigned N_IN   = 5;
  localparam int unsigned N_TERM = 4;
  localparam int unsigned N_OUT  = 2;
  localparam int unsigned AW     = 2;
  localparam int unsigned CW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic              cfg_sel = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [CW-1:0]     cfg_wdata = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_IN-1:0]   in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N_OUT-1:0]  out_data;

  always #5 clk = ~clk;

  aoi_pla_pipe #(.N_IN(N_IN), .N_TERM(N_TERM), .N_OUT(N_OUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_sel_i   (cfg_sel),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_ready_o (cfg_ready),
    .cfg_err_o   (cfg_err),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the logical function currently programmed.
  logic [N_IN-1:0]   m_and [N_TERM];
  logic [N_TERM-1:0] m_or  [N_OUT];
  logic [N_OUT-1:0]  m_inv;
  logic [N_OUT-1:0]  exp_q [$];
  int                inflight = 0;
  logic              err_exp = 1'b0;
  logic              hold_pend = 1'b0;
  logic [N_OUT-1:0]  hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output o is true when any selected term has every one of its mask inputs high.
  function automatic logic [N_OUT-1:0] model(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] r;
    logic hit;
    r = '0;
    for (int o = 0; o < N_OUT; o++) begin
      hit = 1'b0;
      for (int t = 0; t < N_TERM; t++) begin
        if (m_or[o][t] && (m_and[t] != '0) && ((x & m_and[t]) == m_and[t])) hit = 1'b1;
      end
      r[o] = hit ^ m_inv[o];
    end
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    logic e_cfg_rdy, e_in_rdy, empty, ok;
    if (!rst_n) begin
      for (int t = 0; t < N_TERM; t++) m_and[t] = '0;
      for (int o = 0; o < N_OUT; o++) m_or[o] = '0;
      m_inv = '0;
      exp_q.delete();
      inflight = 0;
      err_exp = 1'b0;
      hold_pend = 1'b0;
    end else begin
      check("cfg_err", 32'(cfg_err), 32'(err_exp));
      empty     = (inflight == 0);
      e_cfg_rdy = empty && (cfg_we || !in_valid);
      e_in_rdy  = ((inflight < 2) || out_ready) && !(cfg_we && empty);
      check("cfg_ready", 32'(cfg_ready), 32'(e_cfg_rdy));
      check("in_ready", 32'(in_ready), 32'(e_in_rdy));
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_unexpected: got beat %0h expected none at %0t", out_data, $time);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          inflight--;
        end
      end
      if (in_valid && e_in_rdy) begin
        exp_q.push_back(model(in_data));
        inflight++;
      end
      if (cfg_we) begin
        ok = e_cfg_rdy && (cfg_sel ? (32'(cfg_addr) < N_OUT) : (32'(cfg_addr) < N_TERM));
        if (ok && !cfg_sel) m_and[cfg_addr] = cfg_wdata[N_IN-1:0];
        if (ok && cfg_sel) begin
          m_or[cfg_addr[0]]  = cfg_wdata[N_TERM-1:0];
          m_inv[cfg_addr[0]] = cfg_wdata[N_TERM];
        end
        err_exp = !ok;
      end else begin
        err_exp = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic sel, input logic [AW-1:0] addr, input logic [CW-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [N_IN-1:0] d);
    int n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected accept", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || inflight != 0) && n < 40) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || inflight != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Cleared planes give 0; invert on output 1 alone forces it high.
    for (int i = 0; i < 3; i++) send(N_IN'($urandom));
    drain();
    cfg_wr(1'b1, 2'd1, 5'b10000);
    for (int i = 0; i < 3; i++) send(N_IN'($urandom));
    drain();
    cfg_wr(1'b1, 2'd1, 5'b00000);

    // AOI function and 2-cycle latency.
    cfg_wr(1'b0, 2'd0, 5'b00111);
    cfg_wr(1'b0, 2'd1, 5'b11000);
    cfg_wr(1'b1, 2'd0, 5'b10011);
    in_valid = 1'b1;
    in_data  = 5'b00111;
    tick();
    in_valid = 1'b0;
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("aoi_00111_out0", 32'(out_data[0]), 32'd0);
    send(5'b11000);
    send(5'b01011);
    drain();

    // Backpressure: 8 beats while the sink stalls for 4 cycles.
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(N_IN'(i));
      begin
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Config while busy is dropped; retry on an empty pipe commits.
    out_ready = 1'b0;
    send(5'b00111);
    tick();
    cfg_wr(1'b0, 2'd0, 5'b00001);
    check("busy_cfg_err", 32'(cfg_err), 32'd1);
    drain();
    cfg_wr(1'b0, 2'd0, 5'b00001);
    send(5'b00001);
    send(5'b00110);
    drain();

    // Out-of-range output row, then config racing an input on an empty pipe.
    cfg_wr(1'b1, 2'd3, 5'b11111);
    check("oor_cfg_err", 32'(cfg_err), 32'd1);
    send(5'b00111);
    drain();
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 2'd1; cfg_wdata = 5'b10000;
    in_valid = 1'b1; in_data = 5'b10101;
    @(negedge clk);
    check("race_in_ready", 32'(in_ready), 32'd0);
    check("race_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    cfg_we = 1'b0;
    send(5'b10101);
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(5'b00111);
    send(5'b11000);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) send(N_IN'($urandom));
    drain();

    // Randomized traffic with interleaved (often rejected) config writes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = N_IN'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_sel   = 1'($urandom);
      cfg_addr  = AW'($urandom);
      cfg_wdata = CW'($urandom);
      tick();
    end
    cfg_we = 1'b0;
    in_valid = 1'b0;
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
